odu_chid_scheduler: RTL and testbench

//  Sequences the ODU data generator across its 80 channel IDs. Walks the enabled-channel map

---
 rtl/odu_sched_pkg.sv | 21 ++
 rtl/odu_timeout_cnt.sv | 47 ++++
 rtl/odu_chid_scheduler.sv | 177 +++++++++++++++++
 tb/tb_odu_chid_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : odu_sched_pkg
//  Description : Shared constants and FSM state encodings for the ODU
//                channel-ID scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package odu_sched_pkg;

    localparam int NUM_CHID     = 80;
    localparam int CHID_WIDTH   = 7;
    localparam int DONE_TIMEOUT = 1024;

    // Scheduler states, 2-bit encoding
    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_scan      = 2'd1;
    localparam logic [1:0] c_st_issue     = 2'd2;
    localparam logic [1:0] c_st_wait_done = 2'd3;

endpackage
`default_nettype wire

// File: rtl/odu_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : odu_timeout_cnt
//  Description : Saturating cycle counter guarding the wait for a datapath
//                completion. o_expire is asserted while enabled on the
//                DONE_TIMEOUT-th counted cycle (count value DONE_TIMEOUT-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module odu_timeout_cnt #(
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int                 c_cnt_w = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DONE_TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;

    // Next count: clear wins, otherwise count up and hold at the last value
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_enable && (r_cnt_q != c_last)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_expire = i_enable && (r_cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/odu_chid_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : odu_chid_scheduler
//  Description : Round-robin scheduler walking the enabled channel-ID map,
//                issuing one generate request per enabled channel over a
//                valid/ready handshake and waiting for the completion pulse
//                (or a timeout) before moving on. Enable/type maps are
//                snapshotted at start and at every pass wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module odu_chid_scheduler
    import odu_sched_pkg::*;
#(
    parameter int NUM_CHID     = odu_sched_pkg::NUM_CHID,
    parameter int CHID_WIDTH   = odu_sched_pkg::CHID_WIDTH,
    parameter int DONE_TIMEOUT = odu_sched_pkg::DONE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CHID-1:0]   cfg_enable_vec,
    input  logic [NUM_CHID-1:0]   cfg_type_vec,
    input  logic                  cfg_start,
    output logic                  gen_valid,
    output logic [CHID_WIDTH-1:0] gen_chid,
    output logic                  gen_type,
    input  logic                  gen_ready,
    input  logic                  gen_done,
    output logic                  status_gen_data,
    output logic                  pass_done,
    output logic                  err_timeout
);

    localparam logic [CHID_WIDTH-1:0] c_ptr_last = CHID_WIDTH'(NUM_CHID - 1);

    logic [1:0]            r_state_q,     w_state_d;
    logic [CHID_WIDTH-1:0] r_ptr_q,       w_ptr_d;
    logic [NUM_CHID-1:0]   r_en_snap_q,   w_en_snap_d;
    logic [NUM_CHID-1:0]   r_type_snap_q, w_type_snap_d;
    logic                  r_valid_q,     w_valid_d;
    logic [CHID_WIDTH-1:0] r_chid_q,      w_chid_d;
    logic                  r_type_q,      w_type_d;
    logic                  r_status_q,    w_status_d;
    logic                  r_pass_q,      w_pass_d;
    logic                  r_err_q,       w_err_d;

    logic w_advance;
    logic w_tmo_clear;
    logic w_tmo_enable;
    logic w_tmo_expire;

    odu_timeout_cnt #(
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_expire (w_tmo_expire)
    );

    // Next-state logic: FSM transitions, pointer advance with pass wrap,
    // and next values for every registered output
    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_en_snap_d   = r_en_snap_q;
        w_type_snap_d = r_type_snap_q;
        w_valid_d     = r_valid_q;
        w_chid_d      = r_chid_q;
        w_type_d      = r_type_q;
        w_err_d       = r_err_q;
        w_pass_d      = 1'b0;
        w_advance     = 1'b0;
        w_tmo_clear   = 1'b1;
        w_tmo_enable  = 1'b0;

        case (r_state_q)
            c_st_idle: begin
                if (cfg_start) begin
                    w_ptr_d       = '0;
                    w_en_snap_d   = cfg_enable_vec;
                    w_type_snap_d = cfg_type_vec;
                    w_err_d       = 1'b0;
                    w_state_d     = c_st_scan;
                end
            end
            c_st_scan: begin
                if (!cfg_start) begin
                    w_state_d = c_st_idle;
                end else if (r_en_snap_q[r_ptr_q]) begin
                    w_chid_d  = r_ptr_q;
                    w_type_d  = r_type_snap_q[r_ptr_q];
                    w_valid_d = 1'b1;
                    w_state_d = c_st_issue;
                end else begin
                    w_advance = 1'b1;
                end
            end
            c_st_issue: begin
                // Request is held until accepted, regardless of cfg_start
                if (gen_ready) begin
                    w_valid_d = 1'b0;
                    if (gen_done) begin
                        w_advance = 1'b1;
                        w_state_d = c_st_scan;
                    end else begin
                        w_state_d = c_st_wait_done;
                    end
                end
            end
            c_st_wait_done: begin
                w_tmo_clear  = 1'b0;
                w_tmo_enable = 1'b1;
                if (gen_done || w_tmo_expire) begin
                    if (!gen_done) begin
                        w_err_d = 1'b1;
                    end
                    w_advance = 1'b1;
                    w_state_d = cfg_start ? c_st_scan : c_st_idle;
                end
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase

        // Leaving the last channel closes the pass and loads fresh config
        if (w_advance) begin
            if (r_ptr_q == c_ptr_last) begin
                w_ptr_d       = '0;
                w_pass_d      = 1'b1;
                w_en_snap_d   = cfg_enable_vec;
                w_type_snap_d = cfg_type_vec;
            end else begin
                w_ptr_d = r_ptr_q + 1'b1;
            end
        end

        w_status_d = (w_state_d != c_st_idle);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_st_idle;
            r_ptr_q       <= '0;
            r_en_snap_q   <= '0;
            r_type_snap_q <= '0;
            r_valid_q     <= 1'b0;
            r_chid_q      <= '0;
            r_type_q      <= 1'b0;
            r_status_q    <= 1'b0;
            r_pass_q      <= 1'b0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_en_snap_q   <= w_en_snap_d;
            r_type_snap_q <= w_type_snap_d;
            r_valid_q     <= w_valid_d;
            r_chid_q      <= w_chid_d;
            r_type_q      <= w_type_d;
            r_status_q    <= w_status_d;
            r_pass_q      <= w_pass_d;
            r_err_q       <= w_err_d;
        end
    end

    assign gen_valid       = r_valid_q;
    assign gen_chid        = r_chid_q;
    assign gen_type        = r_type_q;
    assign status_gen_data = r_status_q;
    assign pass_done       = r_pass_q;
    assign err_timeout     = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_odu_chid_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odu_chid_scheduler
//  Description : Self-checking bench for odu_chid_scheduler. A time-based
//                reference model predicts, from the enable snapshot, the edge
//                at which each request or pass wrap occurs (one channel
//                examined per cycle) and the handshake/timeout outcomes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odu_chid_scheduler;

    localparam int NCH = 80;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] cfg_enable_vec = '0;
    logic [79:0] cfg_type_vec   = '0;
    logic        cfg_start = 1'b0;
    logic        gen_ready = 1'b0;
    logic        gen_done  = 1'b0;
    logic        gen_valid;
    logic [6:0]  gen_chid;
    logic        gen_type;
    logic        status_gen_data;
    logic        pass_done;
    logic        err_timeout;

    odu_chid_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_enable_vec  (cfg_enable_vec),
        .cfg_type_vec    (cfg_type_vec),
        .cfg_start       (cfg_start),
        .gen_valid       (gen_valid),
        .gen_chid        (gen_chid),
        .gen_type        (gen_type),
        .gen_ready       (gen_ready),
        .gen_done        (gen_done),
        .status_gen_data (status_gen_data),
        .pass_done       (pass_done),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: phase 0 idle, 1 seeking, 2 requesting, 3 awaiting done
    int          m_ph = 0;
    int          m_pos, m_t, m_tgt, m_q, m_wait0;
    logic [79:0] s_en = '0, s_ty = '0;
    bit          e_valid = 0, e_pass = 0, e_stat = 0, e_err = 0;
    int          e_chid = 0, e_type = 0;

    int   dut_log[$];
    int   dut_tlog[$];
    int   dut_pass  = 0;
    int   done_at   = -1;
    logic start_lvl = 1'b0;
    int   t1_exp[6] = '{0, 5, 79, 0, 5, 79};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Next enabled channel after m_pos in this pass and the edge it is reached;
    // with none left, the edge at which the last channel is passed (wrap).
    function automatic void plan();
        m_q = NCH;
        for (int i = m_pos + 1; i < NCH; i++) begin
            if (s_en[i]) begin
                m_q = i;
                break;
            end
        end
        if (m_q < NCH) m_tgt = m_t + (m_q - m_pos);
        else           m_tgt = m_t + (NCH - 1 - m_pos);
    endfunction

    function automatic void complete();
        if (m_q == NCH - 1) begin
            e_pass = 1;
            s_en   = cfg_enable_vec;
            s_ty   = cfg_type_vec;
            m_pos  = -1;
        end else begin
            m_pos = m_q;
        end
        m_t = cyc;
    endfunction

    function automatic void model_edge();
        e_pass = 0;
        if (rst) begin
            m_ph = 0; e_err = 0; e_chid = 0; e_type = 0;
        end else begin
            case (m_ph)
                0: if (cfg_start) begin
                    s_en = cfg_enable_vec; s_ty = cfg_type_vec; e_err = 0;
                    m_pos = -1; m_t = cyc; plan(); m_ph = 1;
                end
                1: if (!cfg_start) begin
                    m_ph = 0;
                end else if (cyc == m_tgt) begin
                    if (m_q < NCH) begin
                        m_ph = 2; e_chid = m_q; e_type = int'(s_ty[m_q]);
                    end else begin
                        e_pass = 1; s_en = cfg_enable_vec; s_ty = cfg_type_vec;
                        m_pos = -1; m_t = cyc; plan();
                    end
                end
                2: if (gen_ready) begin
                    if (gen_done) begin
                        complete(); plan(); m_ph = 1;
                    end else begin
                        m_ph = 3; m_wait0 = cyc;
                    end
                end
                default: if (gen_done || cyc == m_wait0 + TMO) begin
                    if (!gen_done) e_err = 1;
                    complete();
                    if (cfg_start) begin plan(); m_ph = 1; end
                    else m_ph = 0;
                end
            endcase
        end
        e_valid = (m_ph == 2);
        e_stat  = (m_ph != 0);
    endfunction

    task automatic tick(input logic st, input logic rdy, input logic dn);
        cfg_start = st; gen_ready = rdy; gen_done = dn;
        if (!rst && gen_valid && rdy) begin
            dut_log.push_back(int'(gen_chid));
            dut_tlog.push_back(int'(gen_type));
        end
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if (pass_done) dut_pass++;
        chk("gen_valid", gen_valid, e_valid);
        chk("status", status_gen_data, e_stat);
        chk("pass_done", pass_done, e_pass);
        chk("err_timeout", err_timeout, e_err);
        if (e_valid) begin
            chk("gen_chid", gen_chid, e_chid);
            chk("gen_type", gen_type, e_type);
        end
    endtask

    // Datapath responder: random ready, done dl cycles after accept, plus stray done noise
    task automatic run(input int n, input int rpct, input int dmin, input int dmax, input bit hold);
        for (int k = 0; k < n; k++) begin
            logic r, d;
            int   dl;
            r = ($urandom_range(0, 99) < rpct);
            d = (!hold && done_at == cyc + 1) || (!hold && rpct < 100 && $urandom_range(0, 29) == 0);
            if (gen_valid && r) begin
                dl = $urandom_range(dmin, dmax);
                if (dl == 0) d = !hold;
                else done_at = cyc + 1 + dl;
            end
            tick(start_lvl, r, d);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        done_at = -1; start_lvl = 1'b0; dut_pass = 0;
        dut_log.delete(); dut_tlog.delete();
    endtask

    task automatic wait_valid(input string tag, input logic st, input int limit);
        int k;
        k = 0;
        while (!gen_valid && k < limit) begin
            tick(st, 1'b0, 1'b0);
            k++;
        end
        if (!gen_valid) chk(tag, 0, 1);
    endtask

    function automatic int log_at(input int i);
        return (i < dut_log.size()) ? dut_log[i] : -1;
    endfunction

    initial begin
        int nv;
        int dens;

        // 1: channels 0,5,79, type only on 5, done 3 cycles after accept
        do_reset();
        chk("rst_valid", gen_valid, 0);
        chk("rst_chid", gen_chid, 0);
        chk("rst_type", gen_type, 0);
        chk("rst_status", status_gen_data, 0);
        chk("rst_pass", pass_done, 0);
        chk("rst_err", err_timeout, 0);
        cfg_enable_vec = '0; cfg_type_vec = '0;
        cfg_enable_vec[0] = 1'b1; cfg_enable_vec[5] = 1'b1; cfg_enable_vec[79] = 1'b1;
        cfg_type_vec[5] = 1'b1;
        start_lvl = 1'b1;
        run(300, 100, 3, 3, 0);
        for (int i = 0; i < 6; i++) chk("t1_order", log_at(i), t1_exp[i]);
        chk("t1_type5", (dut_tlog.size() > 1) ? dut_tlog[1] : -1, 1);
        chk("t1_type0", (dut_tlog.size() > 0) ? dut_tlog[0] : -1, 0);
        chk("t1_type79", (dut_tlog.size() > 2) ? dut_tlog[2] : -1, 0);
        chk("t1_passes", (dut_pass >= 2), 1);

        // 2: ready withheld 10 cycles while a request is pending
        do_reset();
        cfg_enable_vec = '0; cfg_type_vec = '0;
        cfg_enable_vec[3] = 1'b1; cfg_type_vec[3] = 1'b1;
        wait_valid("t2_wait_valid", 1'b1, 20);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            chk("t2_hold_valid", gen_valid, 1);
            chk("t2_hold_chid", gen_chid, 3);
            chk("t2_hold_type", gen_type, 1);
        end
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("t2_one_accept", dut_log.size(), 1);
        start_lvl = 1'b1;
        run(200, 100, 1, 1, 0);

        // 3: nothing enabled -> pass_done every 80 cycles, no requests
        do_reset();
        cfg_enable_vec = '0;
        start_lvl = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        dut_pass = 0;
        run(240, 100, 0, 0, 0);
        chk("t3_pass_count", dut_pass, 3);
        chk("t3_no_req", dut_log.size(), 0);
        chk("t3_status", status_gen_data, 1);

        // 4: stop while waiting for done on chid 5
        do_reset();
        cfg_enable_vec = '0; cfg_enable_vec[5] = 1'b1;
        wait_valid("t4_wait_valid", 1'b1, 20);
        chk("t4_chid", gen_chid, 5);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("t4_status_busy", status_gen_data, 1);
        tick(1'b0, 1'b1, 1'b1);
        chk("t4_status_idle", status_gen_data, 0);
        nv = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (gen_valid) nv++;
        end
        chk("t4_no_req", nv, 0);

        // 5: withheld done -> timeout, next channel served, error cleared on restart
        do_reset();
        cfg_enable_vec = '0; cfg_enable_vec[10] = 1'b1; cfg_enable_vec[20] = 1'b1;
        wait_valid("t5_wait_valid", 1'b1, 30);
        chk("t5_chid10", gen_chid, 10);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TMO - 1; i++) tick(1'b1, 1'b1, 1'b0);
        chk("t5_err_before", err_timeout, 0);
        tick(1'b1, 1'b1, 1'b0);
        chk("t5_err_set", err_timeout, 1);
        wait_valid("t5_wait_next", 1'b1, 30);
        chk("t5_chid20", gen_chid, 20);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("t5_idle", status_gen_data, 0);
        chk("t5_err_sticky", err_timeout, 1);
        tick(1'b1, 1'b0, 1'b0);
        chk("t5_err_clear", err_timeout, 0);

        // 6: enable chid 2 mid-pass -> only served next pass; then reset during a request
        do_reset();
        cfg_enable_vec = '0; cfg_enable_vec[60] = 1'b1;
        start_lvl = 1'b1;
        run(40, 100, 2, 2, 0);
        cfg_enable_vec[2] = 1'b1;
        run(250, 100, 2, 2, 0);
        chk("t6_first", log_at(0), 60);
        chk("t6_second", log_at(1), 2);
        chk("t6_third", log_at(2), 60);
        wait_valid("t6_wait_valid", 1'b1, 100);
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t6_rst_valid", gen_valid, 0);
        chk("t6_rst_chid", gen_chid, 0);
        chk("t6_rst_type", gen_type, 0);
        chk("t6_rst_status", status_gen_data, 0);
        chk("t6_rst_pass", pass_done, 0);
        chk("t6_rst_err", err_timeout, 0);

        // Randomized rounds: random maps, ready, done delay, mid-run changes and stops
        for (int r = 0; r < 6; r++) begin
            do_reset();
            dens = $urandom_range(0, 30);
            for (int i = 0; i < NCH; i++) begin
                cfg_enable_vec[i] = ($urandom_range(0, 99) < dens);
                cfg_type_vec[i]   = $urandom_range(0, 1);
            end
            start_lvl = 1'b1;
            run(300, $urandom_range(30, 100), 0, 4, 0);
            for (int i = 0; i < NCH; i++) cfg_enable_vec[i] = ($urandom_range(0, 99) < dens + 5);
            start_lvl = 1'b0;
            run(20, 100, 0, 2, 0);
            start_lvl = 1'b1;
            run(200, $urandom_range(30, 100), 0, 4, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
